// File: rtl/wbxbc_pipe_slice.sv
// Pipelined Wishbone register slice: 2-entry skid buffer on requests,
// one flop on responses, outstanding-request cap and CYC abort handling.
module wbxbc_pipe_slice #(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGC_WIDTH  = 1,
  parameter int TGRD_WIDTH = 1,
  parameter int TGWD_WIDTH = 1,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  sync_rst_i,
  input  logic                  itr_cyc_i,
  input  logic                  itr_stb_i,
  input  logic                  itr_we_i,
  input  logic                  itr_lock_i,
  input  logic [SEL_WIDTH-1:0]  itr_sel_i,
  input  logic [ADR_WIDTH-1:0]  itr_adr_i,
  input  logic [DAT_WIDTH-1:0]  itr_dat_i,
  input  logic [TGA_WIDTH-1:0]  itr_tga_i,
  input  logic [TGC_WIDTH-1:0]  itr_tgc_i,
  input  logic [TGWD_WIDTH-1:0] itr_tgd_i,
  output logic                  itr_ack_o,
  output logic                  itr_err_o,
  output logic                  itr_rty_o,
  output logic                  itr_stall_o,
  output logic [DAT_WIDTH-1:0]  itr_dat_o,
  output logic [TGRD_WIDTH-1:0] itr_tgd_o,
  output logic                  tgt_cyc_o,
  output logic                  tgt_stb_o,
  output logic                  tgt_we_o,
  output logic                  tgt_lock_o,
  output logic [SEL_WIDTH-1:0]  tgt_sel_o,
  output logic [ADR_WIDTH-1:0]  tgt_adr_o,
  output logic [DAT_WIDTH-1:0]  tgt_dat_o,
  output logic [TGA_WIDTH-1:0]  tgt_tga_o,
  output logic [TGC_WIDTH-1:0]  tgt_tgc_o,
  output logic [TGWD_WIDTH-1:0] tgt_tgd_o,
  input  logic                  tgt_ack_i,
  input  logic                  tgt_err_i,
  input  logic                  tgt_rty_i,
  input  logic                  tgt_stall_i,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
  input  logic [TGRD_WIDTH-1:0] tgt_tgd_i
);

  localparam int OW = $clog2(OUT_DEPTH + 1);
  localparam int PW = 2 + SEL_WIDTH + ADR_WIDTH + DAT_WIDTH
                    + TGA_WIDTH + TGC_WIDTH + TGWD_WIDTH;

  logic [PW-1:0] ent0, ent1, ent0_n, ent1_n, pld;
  logic [1:0]    buf_cnt, buf_n;
  logic [OW-1:0] out_cnt, out_n;
  logic [OW:0]   sum_n;
  logic          acc, pop, abort, term, hit, stall_n;
  logic          head_lock, lock_last;

  assign pld = {itr_we_i, itr_lock_i, itr_sel_i, itr_adr_i,
                itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i};

  assign {tgt_we_o, head_lock, tgt_sel_o, tgt_adr_o,
          tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o} = ent0;

  assign tgt_stb_o = (buf_cnt != 2'd0);
  assign acc   = itr_cyc_i & itr_stb_i & ~itr_stall_o;
  assign pop   = tgt_stb_o & ~tgt_stall_i;
  assign abort = ~itr_cyc_i & (tgt_stb_o | (out_cnt != '0));
  assign term  = tgt_ack_i | tgt_err_i | tgt_rty_i;
  // a termination only belongs to us if something is (or is just being) issued
  assign hit   = term & ((out_cnt != '0) | pop) & ~abort;

  assign tgt_lock_o = tgt_stb_o ? head_lock : (tgt_cyc_o & lock_last);

  always_comb begin
    ent0_n = ent0;
    ent1_n = ent1;
    buf_n  = buf_cnt;
    out_n  = out_cnt;
    if (pop) begin
      ent0_n = ent1;
      buf_n  = buf_n - 2'd1;
    end
    if (acc) begin
      if (buf_n == 2'd0) ent0_n = pld;
      else               ent1_n = pld;
      buf_n = buf_n + 2'd1;
    end
    if (pop & ~hit)      out_n = out_cnt + OW'(1);
    else if (hit & ~pop) out_n = out_cnt - OW'(1);
    if (abort) begin
      buf_n = '0;
      out_n = '0;
    end
    sum_n   = {1'b0, out_n} + (OW+1)'(buf_n);
    stall_n = (buf_n == 2'd2) | (sum_n >= (OW+1)'(OUT_DEPTH));
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      ent0        <= '0;
      ent1        <= '0;
      buf_cnt     <= '0;
      out_cnt     <= '0;
      itr_stall_o <= 1'b0;
      tgt_cyc_o   <= 1'b0;
      lock_last   <= 1'b0;
      itr_ack_o   <= 1'b0;
      itr_err_o   <= 1'b0;
      itr_rty_o   <= 1'b0;
      itr_dat_o   <= '0;
      itr_tgd_o   <= '0;
    end else if (sync_rst_i) begin
      ent0        <= '0;
      ent1        <= '0;
      buf_cnt     <= '0;
      out_cnt     <= '0;
      itr_stall_o <= 1'b0;
      tgt_cyc_o   <= 1'b0;
      lock_last   <= 1'b0;
      itr_ack_o   <= 1'b0;
      itr_err_o   <= 1'b0;
      itr_rty_o   <= 1'b0;
      itr_dat_o   <= '0;
      itr_tgd_o   <= '0;
    end else begin
      ent0        <= ent0_n;
      ent1        <= ent1_n;
      buf_cnt     <= buf_n;
      out_cnt     <= out_n;
      itr_stall_o <= stall_n;
      tgt_cyc_o   <= (itr_cyc_i | tgt_stb_o | (out_cnt != '0)) & ~abort;
      if (tgt_stb_o) lock_last <= head_lock;
      itr_err_o   <= hit & tgt_err_i;
      itr_rty_o   <= hit & tgt_rty_i & ~tgt_err_i;
      itr_ack_o   <= hit & tgt_ack_i & ~tgt_err_i & ~tgt_rty_i;
      if (hit) begin
        itr_dat_o <= tgt_dat_i;
        itr_tgd_o <= tgt_tgd_i;
      end
    end
  end

endmodule

// File: tb/tb_wbxbc_pipe_slice.sv
// Bench for wbxbc_pipe_slice: directed scenarios plus random traffic,
// request/response scoreboards fed by a transaction-count model.
module tb_wbxbc_pipe_slice;

  localparam int OD = 4;

  logic clk = 1'b0;
  logic async_rst = 1'b1, sync_rst = 1'b0;
  logic itr_cyc = 0, itr_stb = 0, itr_we = 0, itr_lock = 0;
  logic [1:0]  itr_sel = '0;
  logic [15:0] itr_adr = '0, itr_dat = '0;
  logic itr_tga = 0, itr_tgc = 0, itr_tgd = 0;
  logic tgt_ack = 0, tgt_err = 0, tgt_rty = 0, tgt_stall = 0;
  logic [15:0] tgt_dat = '0;
  logic tgt_tgd = 0;

  logic itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o;
  logic [15:0] itr_dat_o;
  logic itr_tgd_o;
  logic tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o;
  logic [1:0]  tgt_sel_o;
  logic [15:0] tgt_adr_o, tgt_dat_o;
  logic tgt_tga_o, tgt_tgc_o, tgt_tgd_o;

  always #5 clk = ~clk;

  wbxbc_pipe_slice dut (
    .clk_i(clk), .async_rst_i(async_rst), .sync_rst_i(sync_rst),
    .itr_cyc_i(itr_cyc), .itr_stb_i(itr_stb), .itr_we_i(itr_we),
    .itr_lock_i(itr_lock), .itr_sel_i(itr_sel), .itr_adr_i(itr_adr),
    .itr_dat_i(itr_dat), .itr_tga_i(itr_tga), .itr_tgc_i(itr_tgc),
    .itr_tgd_i(itr_tgd),
    .itr_ack_o(itr_ack_o), .itr_err_o(itr_err_o), .itr_rty_o(itr_rty_o),
    .itr_stall_o(itr_stall_o), .itr_dat_o(itr_dat_o), .itr_tgd_o(itr_tgd_o),
    .tgt_cyc_o(tgt_cyc_o), .tgt_stb_o(tgt_stb_o), .tgt_we_o(tgt_we_o),
    .tgt_lock_o(tgt_lock_o), .tgt_sel_o(tgt_sel_o), .tgt_adr_o(tgt_adr_o),
    .tgt_dat_o(tgt_dat_o), .tgt_tga_o(tgt_tga_o), .tgt_tgc_o(tgt_tgc_o),
    .tgt_tgd_o(tgt_tgd_o),
    .tgt_ack_i(tgt_ack), .tgt_err_i(tgt_err), .tgt_rty_i(tgt_rty),
    .tgt_stall_i(tgt_stall), .tgt_dat_i(tgt_dat), .tgt_tgd_i(tgt_tgd)
  );

  typedef struct packed {
    logic [2:0]  k;
    logic [15:0] d;
    logic        t;
  } rsp_t;

  logic [38:0] exp_req[$];
  rsp_t        exp_rsp[$];
  int tests = 0, fails = 0;
  int bcnt = 0, ocnt = 0;
  bit p_acc, p_pop, p_term, p_abort, p_srst, p_cyc;
  logic [38:0] mon_e;
  rsp_t mon_r, new_r;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [38:0] cur_pld();
    return {itr_we, itr_lock, itr_sel, itr_adr,
            itr_dat, itr_tga, itr_tgc, itr_tgd};
  endfunction

  function automatic logic [38:0] dut_pld();
    return {tgt_we_o, tgt_lock_o, tgt_sel_o, tgt_adr_o,
            tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o};
  endfunction

  function automatic logic [44:0] all_outs();
    return {itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o, itr_dat_o,
            itr_tgd_o, tgt_cyc_o, tgt_stb_o, dut_pld()};
  endfunction

  // advance to just after the next edge and apply the transaction counts
  task automatic tick();
    @(posedge clk);
    #1;
    if (p_srst || p_abort) begin
      bcnt = 0;
      ocnt = 0;
      exp_req.delete();
      if (p_srst) exp_rsp.delete();
    end else begin
      bcnt = bcnt + int'(p_acc) - int'(p_pop);
      ocnt = ocnt + int'(p_pop) - int'(p_term);
    end
    chk("stall", 64'(itr_stall_o), 64'(bcnt == 2 || bcnt + ocnt >= OD));
    chk("stb", 64'(tgt_stb_o), 64'(bcnt != 0));
    chk("tgt_cyc", 64'(tgt_cyc_o), 64'(p_cyc && !p_abort));
  endtask

  // record what the edge about to come will do with the driven inputs
  task automatic commit();
    bit tv;
    p_srst  = sync_rst;
    p_abort = !itr_cyc && (bcnt != 0 || ocnt != 0);
    p_acc   = itr_cyc && itr_stb && !itr_stall_o;
    p_pop   = tgt_stb_o && !tgt_stall;
    tv = (tgt_ack || tgt_err || tgt_rty) && (ocnt > 0 || p_pop) && !p_abort;
    p_term  = tv;
    if (!p_srst) begin
      if (p_acc) exp_req.push_back(cur_pld());
      if (tv) begin
        new_r.k = tgt_err ? 3'b100 : (tgt_rty ? 3'b010 : 3'b001);
        new_r.d = tgt_dat;
        new_r.t = tgt_tgd;
        exp_rsp.push_back(new_r);
      end
    end
    p_cyc = itr_cyc && !p_srst;
  endtask

  task automatic go();
    commit();
    tick();
  endtask

  task automatic rnd_req();
    itr_we   = 1'($urandom);
    itr_lock = 1'($urandom);
    itr_sel  = 2'($urandom);
    itr_adr  = 16'($urandom);
    itr_dat  = 16'($urandom);
    itr_tga  = 1'($urandom);
    itr_tgc  = 1'($urandom);
    itr_tgd  = 1'($urandom);
  endtask

  task automatic drain();
    itr_cyc = 1; itr_stb = 0; tgt_stall = 0; tgt_err = 0; tgt_rty = 0;
    for (int i = 0; i < 40 && (bcnt + ocnt) > 0; i++) begin
      tgt_ack = (ocnt > 0);
      tgt_dat = 16'($urandom);
      go();
    end
    tgt_ack = 0;
    go();
    chk("drain", 64'(bcnt + ocnt), 64'd0);
  endtask

  task automatic single_read(input logic [15:0] a, input logic [15:0] d);
    tgt_ack = 0; tgt_stall = 0;
    itr_cyc = 1; itr_stb = 1; itr_we = 0; itr_lock = 0; itr_sel = 2'b11;
    itr_adr = a; itr_dat = '0; itr_tga = 0; itr_tgc = 0; itr_tgd = 0;
    go();
    chk("sr_stb", 64'(tgt_stb_o), 64'd1);
    chk("sr_adr", 64'(tgt_adr_o), 64'(a));
    itr_stb = 0;
    go();
    chk("sr_early", 64'(itr_ack_o), 64'd0);
    tgt_ack = 1; tgt_dat = d; tgt_tgd = 1;
    go();
    tgt_ack = 0;
    chk("sr_ack", 64'(itr_ack_o), 64'd1);
    chk("sr_dat", 64'(itr_dat_o), 64'(d));
    itr_cyc = 0;
    go();
  endtask

  always @(negedge clk) begin
    if (!async_rst) begin
      if (tgt_stb_o && !tgt_stall) begin
        if (exp_req.size() == 0) chk("req_unexp", 64'(tgt_stb_o), 64'd0);
        else begin
          mon_e = exp_req.pop_front();
          chk("req_pld", 64'(dut_pld()), 64'(mon_e));
        end
      end
      if (itr_ack_o || itr_err_o || itr_rty_o) begin
        if (exp_rsp.size() == 0)
          chk("rsp_unexp", 64'({itr_err_o, itr_rty_o, itr_ack_o}), 64'd0);
        else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_kind", 64'({itr_err_o, itr_rty_o, itr_ack_o}), 64'(mon_r.k));
          chk("rsp_dat", 64'({itr_dat_o, itr_tgd_o}), 64'({mon_r.d, mon_r.t}));
        end
      end
    end
  end

  initial begin
    int n;
    bit pend;
    int r;
    #3;
    chk("rst_outs", 64'(all_outs()), 64'd0);
    #20 async_rst = 0;
    tick();

    single_read(16'h1234, 16'hbeef);

    // stalled target with three back-to-back requests
    itr_cyc = 1; tgt_ack = 0; n = 0;
    for (int c = 0; c < 12; c++) begin
      tgt_stall = (c < 5);
      if (n < 3) begin
        itr_stb = 1; itr_adr = 16'h0100 + 16'(n); itr_dat = 16'h0a00 + 16'(n);
      end else itr_stb = 0;
      if (c >= 2 && c < 5) begin
        chk("t2_stall", 64'(itr_stall_o), 64'd1);
        chk("t2_adr", 64'(tgt_adr_o), 64'h0100);
      end
      go();
      if (p_acc) n++;
    end
    chk("t2_n", 64'(n), 64'd3);
    drain();

    // outstanding cap with a silent target
    n = 0; itr_cyc = 1; tgt_stall = 0;
    for (int c = 0; c < 10; c++) begin
      itr_stb = 1; itr_adr = 16'h0200 + 16'(n);
      go();
      if (p_acc) n++;
    end
    chk("t3_cap", 64'(n), 64'd4);
    chk("t3_stall", 64'(itr_stall_o), 64'd1);
    tgt_ack = 1; tgt_dat = 16'h3333;
    go();
    if (p_acc) n++;
    tgt_ack = 0;
    for (int c = 0; c < 6; c++) begin
      itr_adr = 16'h0200 + 16'(n);
      go();
      if (p_acc) n++;
    end
    chk("t3_one", 64'(n), 64'd5);
    drain();

    // abort with two outstanding
    itr_cyc = 1; itr_stb = 1; itr_adr = 16'h0300;
    go();
    itr_adr = 16'h0301;
    go();
    itr_stb = 0;
    for (int c = 0; c < 5 && bcnt != 0; c++) go();
    itr_cyc = 0; tgt_ack = 1; tgt_dat = 16'h4444;
    go();
    chk("t4_cyc", 64'(tgt_cyc_o), 64'd0);
    chk("t4_stb", 64'(tgt_stb_o), 64'd0);
    go();
    tgt_ack = 0;
    chk("t4_drop1", 64'(itr_ack_o), 64'd0);
    go();
    chk("t4_drop2", 64'(itr_ack_o), 64'd0);
    n = 0; itr_cyc = 1; itr_stb = 1;
    for (int c = 0; c < 4; c++) begin
      itr_adr = 16'h0310 + 16'(c);
      go();
      if (p_acc) n++;
    end
    chk("t4_cnt", 64'(n), 64'd4);
    drain();

    // simultaneous err+ack, then a stray ack
    itr_cyc = 1; itr_stb = 1; itr_adr = 16'h0400;
    go();
    itr_stb = 0;
    go();
    tgt_err = 1; tgt_ack = 1; tgt_dat = 16'h5a5a;
    go();
    tgt_err = 0; tgt_ack = 0;
    chk("t5_err", 64'(itr_err_o), 64'd1);
    chk("t5_ack", 64'(itr_ack_o), 64'd0);
    tgt_ack = 1;
    go();
    tgt_ack = 0;
    chk("t5_stray", 64'(itr_ack_o), 64'd0);

    // random traffic with occasional aborts and one sync reset
    pend = 0;
    for (int c = 0; c < 800; c++) begin
      sync_rst = (c == 400);
      if ($urandom_range(59, 0) == 0) begin
        itr_cyc = 0; itr_stb = 0; pend = 0;
      end else begin
        itr_cyc = 1;
        if (!pend) begin
          itr_stb = 1'($urandom);
          rnd_req();
        end
      end
      tgt_stall = ($urandom_range(3, 0) == 0);
      r = int'($urandom_range(7, 0));
      tgt_ack = (r <= 2) || (r == 5);
      tgt_err = (r == 3) || (r == 5);
      tgt_rty = (r == 4);
      tgt_dat = 16'($urandom);
      tgt_tgd = 1'($urandom);
      go();
      pend = itr_stb && !p_acc;
      if (p_srst) pend = 0;
    end
    sync_rst = 0; tgt_err = 0; tgt_rty = 0;
    drain();
    chk("q_req", 64'(exp_req.size()), 64'd0);
    chk("q_rsp", 64'(exp_rsp.size()), 64'd0);

    // asynchronous reset in the middle of a burst
    itr_cyc = 1; tgt_stall = 0;
    for (int c = 0; c < 6; c++) begin
      itr_stb = 1; rnd_req();
      tgt_ack = (ocnt > 0); tgt_dat = 16'($urandom);
      go();
    end
    #2 async_rst = 1;
    itr_cyc = 0; itr_stb = 0; tgt_ack = 0; tgt_err = 0; tgt_rty = 0;
    #1;
    chk("arst_outs", 64'(all_outs()), 64'd0);
    exp_req.delete(); exp_rsp.delete();
    bcnt = 0; ocnt = 0;
    p_acc = 0; p_pop = 0; p_term = 0; p_abort = 0; p_srst = 0; p_cyc = 0;
    @(posedge clk);
    @(negedge clk);
    #1 async_rst = 0;
    tick();
    single_read(16'h5678, 16'hc0de);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
